// File: rtl/systolic_array_scheduler_pkg.sv
// Shared types and helpers for the systolic array scheduler.
// Optional perf counters are enabled with SCHED_PERF_CNT_EN.
package systolic_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } sched_state_e;

  localparam int unsigned PERF_CNT_WIDTH = 32;

  // LSB of lane 'lane' inside a packed multi-lane bus
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/systolic_array_scheduler_if.sv
// Edge-stream bundle between the operand sources, the PE array edges and the result sink.
interface systolic_array_scheduler_if #(
  parameter int unsigned PE_NUMBER_I = 4,
  parameter int unsigned PE_NUMBER_J = 4,
  parameter int unsigned OP0_WIDTH   = 16,
  parameter int unsigned OP1_WIDTH   = 16,
  parameter int unsigned PSUM_WIDTH  = OP0_WIDTH + OP1_WIDTH
);

  logic [PE_NUMBER_J*OP0_WIDTH-1:0]  s_axis_a_tdata;
  logic                              s_axis_a_tvalid;
  logic                              s_axis_a_tready;

  logic [PE_NUMBER_J*OP0_WIDTH-1:0]  m_axis_l_tdata;
  logic [PE_NUMBER_J-1:0]            m_axis_l_tvalid;
  logic [PE_NUMBER_J-1:0]            m_axis_l_tready;
  logic [PE_NUMBER_J-1:0]            m_axis_l_tlast;

  logic [PE_NUMBER_I*OP1_WIDTH-1:0]  s_axis_w_tdata;
  logic                              s_axis_w_tvalid;
  logic                              s_axis_w_tready;

  logic [PE_NUMBER_I*OP1_WIDTH-1:0]  m_axis_t_tdata;
  logic [PE_NUMBER_I-1:0]            m_axis_t_tvalid;
  logic [PE_NUMBER_I-1:0]            m_axis_t_tready;
  logic [PE_NUMBER_I-1:0]            m_axis_t_tlast;

  logic [PE_NUMBER_I*PSUM_WIDTH-1:0] s_axis_d_tdata;
  logic [PE_NUMBER_I-1:0]            s_axis_d_tvalid;
  logic [PE_NUMBER_I-1:0]            s_axis_d_tready;
  logic [PE_NUMBER_I-1:0]            s_axis_d_tlast;

  logic [PE_NUMBER_I*PSUM_WIDTH-1:0] m_axis_res_tdata;
  logic [PE_NUMBER_I-1:0]            m_axis_res_tvalid;
  logic [PE_NUMBER_I-1:0]            m_axis_res_tready;
  logic [PE_NUMBER_I-1:0]            m_axis_res_tlast;

  // Scheduler side
  modport slave (
    input  s_axis_a_tdata, s_axis_a_tvalid,
    output s_axis_a_tready,
    output m_axis_l_tdata, m_axis_l_tvalid, m_axis_l_tlast,
    input  m_axis_l_tready,
    input  s_axis_w_tdata, s_axis_w_tvalid,
    output s_axis_w_tready,
    output m_axis_t_tdata, m_axis_t_tvalid, m_axis_t_tlast,
    input  m_axis_t_tready,
    input  s_axis_d_tdata, s_axis_d_tvalid, s_axis_d_tlast,
    output s_axis_d_tready,
    output m_axis_res_tdata, m_axis_res_tvalid, m_axis_res_tlast,
    input  m_axis_res_tready
  );

  // Environment side (sources, array, sink)
  modport master (
    output s_axis_a_tdata, s_axis_a_tvalid,
    input  s_axis_a_tready,
    input  m_axis_l_tdata, m_axis_l_tvalid, m_axis_l_tlast,
    output m_axis_l_tready,
    output s_axis_w_tdata, s_axis_w_tvalid,
    input  s_axis_w_tready,
    input  m_axis_t_tdata, m_axis_t_tvalid, m_axis_t_tlast,
    output m_axis_t_tready,
    output s_axis_d_tdata, s_axis_d_tvalid, s_axis_d_tlast,
    input  s_axis_d_tready,
    input  m_axis_res_tdata, m_axis_res_tvalid, m_axis_res_tlast,
    output m_axis_res_tready
  );

endinterface

// File: rtl/systolic_array_scheduler_fork.sv
// axis_lane_fork: splits one packed source beat into LANES independent edge streams,
// each lane taking the beat exactly once before the source beat is consumed.
module axis_lane_fork
  import systolic_sched_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   last_beat,
  input  logic [LANES*WIDTH-1:0] src_data,
  input  logic                   src_valid,
  output logic                   src_ready,
  output logic                   fire,
  output logic [LANES*WIDTH-1:0] lane_data,
  output logic [LANES-1:0]       lane_valid,
  output logic [LANES-1:0]       lane_last,
  input  logic [LANES-1:0]       lane_ready
);

  logic [LANES-1:0] sent;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam int unsigned LSB = lane_lsb(l, WIDTH);
    assign lane_data[LSB +: WIDTH] = src_data[LSB +: WIDTH];
  end

  assign lane_valid = {LANES{src_valid & en}} & ~sent;
  assign lane_last  = {LANES{en & last_beat}};
  // Source beat retires once every lane has either taken it now or earlier
  assign src_ready  = en & (&(lane_ready | sent));
  assign fire       = src_valid & src_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sent <= '0;
    end else if (fire) begin
      sent <= '0;
    end else begin
      sent <= sent | (lane_valid & lane_ready);
    end
  end

endmodule

// File: rtl/systolic_array_scheduler.sv
// Tile sequencer for an I x J systolic array: forks operand beats to edge lanes,
// frames tiles with tlast, tracks result tlasts. SCHED_PERF_CNT_EN adds perf counters.
module systolic_array_scheduler
  import systolic_sched_pkg::*;
#(
  parameter int unsigned PE_NUMBER_I = 4,
  parameter int unsigned PE_NUMBER_J = 4,
  parameter int unsigned OP0_WIDTH   = 16,
  parameter int unsigned OP1_WIDTH   = 16,
  parameter int unsigned PSUM_WIDTH  = OP0_WIDTH + OP1_WIDTH,
  parameter int unsigned K_WIDTH     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_start,
  input  logic [K_WIDTH-1:0] cfg_k_len,
  input  logic [K_WIDTH-1:0] cfg_tiles,
  output logic               busy,
  output logic               done,
  output logic               err_cfg,
  output logic               err_unaligned,
`ifdef SCHED_PERF_CNT_EN
  output logic [PERF_CNT_WIDTH-1:0] perf_cycles,
  output logic [PERF_CNT_WIDTH-1:0] perf_stall_a,
  output logic [PERF_CNT_WIDTH-1:0] perf_stall_w,
`endif
  systolic_array_scheduler_if.slave bus
);

  sched_state_e           state;
  logic [K_WIDTH-1:0]     k_len;
  logic [K_WIDTH-1:0]     tiles_left;
  logic [K_WIDTH-1:0]     a_cnt;
  logic [K_WIDTH-1:0]     w_cnt;
  logic [PE_NUMBER_I-1:0] col_seen;

  logic a_en, w_en, a_last, w_last, a_fire, w_fire;
  logic [PE_NUMBER_I-1:0] res_fire, last_fire;
  logic in_tile, dup_last, idle_result, cols_done, cfg_ok, start_ok;

  assign a_en   = (state == STREAM) && (a_cnt < k_len);
  assign w_en   = (state == STREAM) && (w_cnt < k_len);
  assign a_last = (a_cnt == k_len - K_WIDTH'(1));
  assign w_last = (w_cnt == k_len - K_WIDTH'(1));

  axis_lane_fork #(.LANES(PE_NUMBER_J), .WIDTH(OP0_WIDTH)) u_fork_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (a_en),
    .last_beat  (a_last),
    .src_data   (bus.s_axis_a_tdata),
    .src_valid  (bus.s_axis_a_tvalid),
    .src_ready  (bus.s_axis_a_tready),
    .fire       (a_fire),
    .lane_data  (bus.m_axis_l_tdata),
    .lane_valid (bus.m_axis_l_tvalid),
    .lane_last  (bus.m_axis_l_tlast),
    .lane_ready (bus.m_axis_l_tready)
  );

  axis_lane_fork #(.LANES(PE_NUMBER_I), .WIDTH(OP1_WIDTH)) u_fork_w (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (w_en),
    .last_beat  (w_last),
    .src_data   (bus.s_axis_w_tdata),
    .src_valid  (bus.s_axis_w_tvalid),
    .src_ready  (bus.s_axis_w_tready),
    .fire       (w_fire),
    .lane_data  (bus.m_axis_t_tdata),
    .lane_valid (bus.m_axis_t_tvalid),
    .lane_last  (bus.m_axis_t_tlast),
    .lane_ready (bus.m_axis_t_tready)
  );

  // Results pass straight through; the scheduler only watches handshakes
  assign bus.m_axis_res_tdata  = bus.s_axis_d_tdata;
  assign bus.m_axis_res_tvalid = bus.s_axis_d_tvalid;
  assign bus.m_axis_res_tlast  = bus.s_axis_d_tlast;
  assign bus.s_axis_d_tready   = bus.m_axis_res_tready;

  assign res_fire    = bus.s_axis_d_tvalid & bus.m_axis_res_tready;
  assign last_fire   = res_fire & bus.s_axis_d_tlast;
  assign in_tile     = (state == STREAM) || (state == DRAIN);
  assign dup_last    = in_tile && (|(last_fire & col_seen));
  assign idle_result = (state == IDLE) && (|res_fire);
  assign cols_done   = &(col_seen | last_fire);
  assign cfg_ok      = (cfg_k_len != '0) && (cfg_tiles != '0);
  assign start_ok    = (state == IDLE) && cfg_start && cfg_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      k_len         <= '0;
      tiles_left    <= '0;
      a_cnt         <= '0;
      w_cnt         <= '0;
      col_seen      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_cfg       <= 1'b0;
      err_unaligned <= 1'b0;
    end else begin
      done    <= 1'b0;
      err_cfg <= 1'b0;
      if (a_fire) a_cnt <= a_cnt + K_WIDTH'(1);
      if (w_fire) w_cnt <= w_cnt + K_WIDTH'(1);
      if (in_tile) col_seen <= col_seen | last_fire;

      unique case (state)
        IDLE: begin
          if (cfg_start) begin
            if (cfg_ok) begin
              k_len         <= cfg_k_len;
              tiles_left    <= cfg_tiles;
              a_cnt         <= '0;
              w_cnt         <= '0;
              col_seen      <= '0;
              busy          <= 1'b1;
              err_unaligned <= 1'b0;
              state         <= STREAM;
            end else begin
              err_cfg <= 1'b1;
            end
          end
        end
        STREAM: begin
          if ((a_cnt == k_len) && (w_cnt == k_len)) state <= DRAIN;
        end
        DRAIN: begin
          if (cols_done) begin
            col_seen   <= '0;
            tiles_left <= tiles_left - K_WIDTH'(1);
            if (tiles_left == K_WIDTH'(1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              a_cnt <= '0;
              w_cnt <= '0;
              state <= STREAM;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A stray result outranks the clear on the same cycle's start
      if (dup_last || idle_result) err_unaligned <= 1'b1;
    end
  end

`ifdef SCHED_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles  <= '0;
      perf_stall_a <= '0;
      perf_stall_w <= '0;
    end else if (start_ok) begin
      perf_cycles  <= '0;
      perf_stall_a <= '0;
      perf_stall_w <= '0;
    end else begin
      if (busy) perf_cycles <= perf_cycles + PERF_CNT_WIDTH'(1);
      if ((state == STREAM) && bus.s_axis_a_tvalid && !bus.s_axis_a_tready)
        perf_stall_a <= perf_stall_a + PERF_CNT_WIDTH'(1);
      if ((state == STREAM) && bus.s_axis_w_tvalid && !bus.s_axis_w_tready)
        perf_stall_w <= perf_stall_w + PERF_CNT_WIDTH'(1);
    end
  end
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_systolic_array_scheduler.sv
// Directed bench for systolic_array_scheduler (I=J=4, 16-bit operands).
// The perf section is compiled only when SCHED_PERF_CNT_EN is defined.
module tb_systolic_array_scheduler;

  localparam int unsigned NI = 4;
  localparam int unsigned NJ = 4;
  localparam int unsigned W0 = 16;
  localparam int unsigned W1 = 16;
  localparam int unsigned WP = 32;
  localparam int unsigned KW = 16;

  localparam logic [63:0]  A_PAT = 64'h0004_0003_0002_0001;
  localparam logic [63:0]  W_PAT = 64'h0040_0030_0020_0010;
  localparam logic [127:0] D_PAT = 128'hDDDD_0004_CCCC_0003_BBBB_0002_AAAA_0001;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_start;
  logic [KW-1:0] cfg_k_len;
  logic [KW-1:0] cfg_tiles;
  logic          busy, done, err_cfg, err_unaligned;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0]   perf_cycles, perf_stall_a, perf_stall_w;
`endif

  systolic_array_scheduler_if #(
    .PE_NUMBER_I(NI), .PE_NUMBER_J(NJ), .OP0_WIDTH(W0), .OP1_WIDTH(W1), .PSUM_WIDTH(WP)
  ) bus ();

  systolic_array_scheduler #(
    .PE_NUMBER_I(NI), .PE_NUMBER_J(NJ), .OP0_WIDTH(W0), .OP1_WIDTH(W1),
    .PSUM_WIDTH(WP), .K_WIDTH(KW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_start     (cfg_start),
    .cfg_k_len     (cfg_k_len),
    .cfg_tiles     (cfg_tiles),
    .busy          (busy),
    .done          (done),
    .err_cfg       (err_cfg),
    .err_unaligned (err_unaligned),
`ifdef SCHED_PERF_CNT_EN
    .perf_cycles   (perf_cycles),
    .perf_stall_a  (perf_stall_a),
    .perf_stall_w  (perf_stall_w),
`endif
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Handshake monitor: per-lane beat and tlast counts, busy cycles, done pulses
  logic mon_clr;
  int   l_fires [NJ];
  int   l_lasts [NJ];
  int   t_fires [NI];
  int   t_lasts [NI];
  int   busy_cycles;
  int   done_pulses;

  always @(posedge clk) begin
    if (mon_clr) begin
      for (int i = 0; i < 4; i++) begin
        l_fires[i] <= 0; l_lasts[i] <= 0; t_fires[i] <= 0; t_lasts[i] <= 0;
      end
      busy_cycles <= 0;
      done_pulses <= 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (bus.m_axis_l_tvalid[i] && bus.m_axis_l_tready[i]) begin
          l_fires[i] <= l_fires[i] + 1;
          if (bus.m_axis_l_tlast[i]) l_lasts[i] <= l_lasts[i] + 1;
        end
        if (bus.m_axis_t_tvalid[i] && bus.m_axis_t_tready[i]) begin
          t_fires[i] <= t_fires[i] + 1;
          if (bus.m_axis_t_tlast[i]) t_lasts[i] <= t_lasts[i] + 1;
        end
      end
      if (busy) busy_cycles <= busy_cycles + 1;
      if (done) done_pulses <= done_pulses + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    logic seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'd1);
  endtask

  task automatic pulse_all_lasts();
    bus.s_axis_d_tvalid = 4'b1111;
    bus.s_axis_d_tlast  = 4'b1111;
    tick();
    bus.s_axis_d_tvalid = 4'b0000;
    bus.s_axis_d_tlast  = 4'b0000;
  endtask

  initial begin
    logic seen;
    rst_n     = 1'b0;
    cfg_start = 1'b0;
    cfg_k_len = '0;
    cfg_tiles = '0;
    mon_clr   = 1'b1;
    bus.s_axis_a_tdata    = A_PAT;
    bus.s_axis_a_tvalid   = 1'b0;
    bus.s_axis_w_tdata    = W_PAT;
    bus.s_axis_w_tvalid   = 1'b0;
    bus.m_axis_l_tready   = 4'b1111;
    bus.m_axis_t_tready   = 4'b1111;
    bus.s_axis_d_tdata    = D_PAT;
    bus.s_axis_d_tvalid   = 4'b0000;
    bus.s_axis_d_tlast    = 4'b0000;
    bus.m_axis_res_tready = 4'b1111;

    // Reset state
    tick(); tick(); #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err_cfg", 64'(err_cfg), 64'd0);
    check("rst_err_unaligned", 64'(err_unaligned), 64'd0);
    check("rst_l_valid", 64'(bus.m_axis_l_tvalid), 64'd0);
    check("rst_t_valid", 64'(bus.m_axis_t_tvalid), 64'd0);
    check("rst_a_ready", 64'(bus.s_axis_a_tready), 64'd0);
    tick();
    rst_n   = 1'b1;
    mon_clr = 1'b0;

    // Result passthrough in IDLE with the sink stalled (no handshake)
    tick();
    bus.m_axis_res_tready = 4'b0000;
    bus.s_axis_d_tvalid   = 4'b0101;
    bus.s_axis_d_tlast    = 4'b0100;
    #1;
    check("res_valid", 64'(bus.m_axis_res_tvalid), 64'h5);
    check("res_last", 64'(bus.m_axis_res_tlast), 64'h4);
    check("res_data_lo", bus.m_axis_res_tdata[63:0], 64'hBBBB_0002_AAAA_0001);
    check("res_data_hi", bus.m_axis_res_tdata[127:64], 64'hDDDD_0004_CCCC_0003);
    check("d_ready", 64'(bus.s_axis_d_tready), 64'h0);
    tick(); #1;
    check("idle_no_hs_err", 64'(err_unaligned), 64'd0);
    bus.s_axis_d_tvalid   = 4'b0000;
    bus.s_axis_d_tlast    = 4'b0000;
    bus.m_axis_res_tready = 4'b1111;

    // Two tiles of K=3, everything ready
    tick();
    mon_clr = 1'b1;
    tick();
    mon_clr   = 1'b0;
    cfg_start = 1'b1; cfg_k_len = 16'd3; cfg_tiles = 16'd2;
    bus.s_axis_a_tvalid = 1'b1;
    bus.s_axis_w_tvalid = 1'b1;
    tick();
    cfg_start = 1'b0; cfg_k_len = 16'd7; cfg_tiles = 16'd9;
    #1;
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_l_valid0", 64'(bus.m_axis_l_tvalid), 64'hF);
    check("t1_t_valid0", 64'(bus.m_axis_t_tvalid), 64'hF);
    check("t1_l_data", bus.m_axis_l_tdata, A_PAT);
    check("t1_t_data", bus.m_axis_t_tdata, W_PAT);
    check("t1_l_last0", 64'(bus.m_axis_l_tlast), 64'h0);
    tick(); #1;
    check("t1_l_last1", 64'(bus.m_axis_l_tlast), 64'h0);
    tick(); #1;
    check("t1_l_last2", 64'(bus.m_axis_l_tlast), 64'hF);
    check("t1_t_last2", 64'(bus.m_axis_t_tlast), 64'hF);
    tick(); #1;
    check("t1_l_valid_k", 64'(bus.m_axis_l_tvalid), 64'h0);
    check("t1_a_ready_k", 64'(bus.s_axis_a_tready), 64'd0);
    tick();
    pulse_all_lasts();
    #1;
    check("t1_tile2_l_valid", 64'(bus.m_axis_l_tvalid), 64'hF);
    check("t1_tile2_l_last", 64'(bus.m_axis_l_tlast), 64'h0);
    tick(); tick(); #1;
    check("t1_tile2_last", 64'(bus.m_axis_t_tlast), 64'hF);
    tick(); tick();
    pulse_all_lasts();
    #1;
    check("t1_done", 64'(done), 64'd1);
    check("t1_busy_at_done", 64'(busy), 64'd0);
    tick(); #1;
    check("t1_done_drop", 64'(done), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_l_fires%0d", i), 64'(l_fires[i]), 64'd6);
      check($sformatf("t1_l_lasts%0d", i), 64'(l_lasts[i]), 64'd2);
      check($sformatf("t1_t_fires%0d", i), 64'(t_fires[i]), 64'd6);
      check($sformatf("t1_t_lasts%0d", i), 64'(t_lasts[i]), 64'd2);
    end
    check("t1_busy_cycles", 64'(busy_cycles), 64'd10);
    check("t1_done_pulses", 64'(done_pulses), 64'd1);
    check("t1_err_unaligned", 64'(err_unaligned), 64'd0);

    // Lane 2 of the left edge stalls for 5 cycles
    mon_clr = 1'b1;
    tick();
    mon_clr   = 1'b0;
    cfg_start = 1'b1; cfg_k_len = 16'd3; cfg_tiles = 16'd1;
    tick();
    cfg_start = 1'b0;
    bus.m_axis_l_tready = 4'b1011;
    #1;
    check("t2_a_ready_stall", 64'(bus.s_axis_a_tready), 64'd0);
    check("t2_l_valid_first", 64'(bus.m_axis_l_tvalid), 64'hF);
    tick(); #1;
    check("t2_l_valid_partial", 64'(bus.m_axis_l_tvalid), 64'h4);
    check("t2_l_fire0", 64'(l_fires[0]), 64'd1);
    check("t2_l_fire2", 64'(l_fires[2]), 64'd0);
    tick(); tick(); tick(); #1;
    check("t2_l_valid_hold", 64'(bus.m_axis_l_tvalid), 64'h4);
    check("t2_l_fire3_hold", 64'(l_fires[3]), 64'd1);
    tick();
    bus.m_axis_l_tready = 4'b1111;
    #1;
    check("t2_a_ready_release", 64'(bus.s_axis_a_tready), 64'd1);
    tick(); #1;
    check("t2_l_valid_next", 64'(bus.m_axis_l_tvalid), 64'hF);
    for (int i = 0; i < 4; i++)
      check($sformatf("t2_one_beat%0d", i), 64'(l_fires[i]), 64'd1);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick(); #1;
      if (l_fires[0] == 3) seen = 1'b1;
    end
    check("t2_beats_drained", 64'(seen), 64'd1);
    pulse_all_lasts();
    wait_done("t2_done");
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_l_fires%0d", i), 64'(l_fires[i]), 64'd3);
      check($sformatf("t2_l_lasts%0d", i), 64'(l_lasts[i]), 64'd1);
    end
    check("t2_t_fires0", 64'(t_fires[0]), 64'd3);

    // Zero K or zero tiles rejected
    tick();
    cfg_start = 1'b1; cfg_k_len = 16'd0; cfg_tiles = 16'd2;
    tick();
    cfg_start = 1'b0;
    #1;
    check("t3_err_cfg_k", 64'(err_cfg), 64'd1);
    check("t3_busy_k", 64'(busy), 64'd0);
    check("t3_l_valid_k", 64'(bus.m_axis_l_tvalid), 64'h0);
    tick(); #1;
    check("t3_err_cfg_drop", 64'(err_cfg), 64'd0);
    check("t3_busy_still0", 64'(busy), 64'd0);
    cfg_start = 1'b1; cfg_k_len = 16'd2; cfg_tiles = 16'd0;
    tick();
    cfg_start = 1'b0;
    #1;
    check("t3_err_cfg_tiles", 64'(err_cfg), 64'd1);
    check("t3_busy_tiles", 64'(busy), 64'd0);

    // Column 1 returns two tlasts in one tile
    tick();
    cfg_start = 1'b1; cfg_k_len = 16'd2; cfg_tiles = 16'd1;
    tick();
    cfg_start = 1'b0;
    bus.s_axis_d_tvalid = 4'b0010;
    bus.s_axis_d_tlast  = 4'b0010;
    tick(); #1;
    check("t4_single_last_ok", 64'(err_unaligned), 64'd0);
    tick();
    #1;
    check("t4_dup_last", 64'(err_unaligned), 64'd1);
    pulse_all_lasts();
    wait_done("t4_done");
    tick(); tick(); #1;
    check("t4_sticky", 64'(err_unaligned), 64'd1);
    cfg_start = 1'b1; cfg_k_len = 16'd1; cfg_tiles = 16'd1;
    tick();
    cfg_start = 1'b0;
    #1;
    check("t4_cleared", 64'(err_unaligned), 64'd0);
    check("t4_k1_last", 64'(bus.m_axis_l_tlast), 64'hF);
    tick();
    pulse_all_lasts();
    wait_done("t4_k1_done");
    check("t4_k1_clean", 64'(err_unaligned), 64'd0);

    // Reset in the middle of a tile, then a clean K=1 run
    tick();
    cfg_start = 1'b1; cfg_k_len = 16'd3; cfg_tiles = 16'd1;
    tick();
    cfg_start = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_l_valid", 64'(bus.m_axis_l_tvalid), 64'h0);
    check("t5_rst_t_valid", 64'(bus.m_axis_t_tvalid), 64'h0);
    check("t5_rst_a_ready", 64'(bus.s_axis_a_tready), 64'd0);
    tick();
    rst_n   = 1'b1;
    mon_clr = 1'b1;
    tick();
    mon_clr   = 1'b0;
    cfg_start = 1'b1; cfg_k_len = 16'd1; cfg_tiles = 16'd1;
    tick();
    cfg_start = 1'b0;
    #1;
    check("t5_k1_valid", 64'(bus.m_axis_l_tvalid), 64'hF);
    check("t5_k1_last", 64'(bus.m_axis_t_tlast), 64'hF);
    check("t5_k1_busy", 64'(busy), 64'd1);
    tick(); #1;
    check("t5_k1_valid_off", 64'(bus.m_axis_l_tvalid), 64'h0);
    pulse_all_lasts();
    wait_done("t5_done");
    check("t5_l_fires1", 64'(l_fires[1]), 64'd1);
    check("t5_err_unaligned", 64'(err_unaligned), 64'd0);
    check("t5_err_cfg", 64'(err_cfg), 64'd0);

`ifdef SCHED_PERF_CNT_EN
    // Weight source idle for 4 STREAM cycles: no weight stall is counted
    bus.s_axis_w_tvalid = 1'b0;
    tick();
    mon_clr = 1'b1;
    tick();
    mon_clr   = 1'b0;
    cfg_start = 1'b1; cfg_k_len = 16'd3; cfg_tiles = 16'd1;
    tick();
    cfg_start = 1'b0;
    tick(); tick(); tick();
    bus.s_axis_a_tvalid = 1'b0;
    pulse_all_lasts();
    bus.s_axis_w_tvalid = 1'b1;
    tick(); tick(); tick();
    bus.s_axis_w_tvalid = 1'b0;
    wait_done("p_done");
    tick(); #1;
    check("p_stall_w", 64'(perf_stall_w), 64'd0);
    check("p_cycles", 64'(perf_cycles), 64'd9);
    check("p_cycles_vs_busy", 64'(perf_cycles), 64'(busy_cycles));
`endif

    bus.s_axis_a_tvalid = 1'b0;
    bus.s_axis_w_tvalid = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
